// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter and the arbiters that reuse rr_arb.
package mem_arb_pkg;

    localparam int MAX_OUT_DEF = 8;
    localparam int IDX_W_DEF   = 4;
    localparam int MCN_W_DEF   = 36;
    localparam int PCN_W_DEF   = 28;
    localparam int DAT_W_DEF   = 512;
    localparam int SRC_W_DEF   = 1;

    // Source tag width: a single requester still gets one tag bit.
    function automatic int src_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [SRC_W_DEF+IDX_W_DEF-1:0] idx;
        logic                           rnw;
        logic [MCN_W_DEF-1:0]           mcn;
        logic [PCN_W_DEF-1:0]           pcn;
        logic [DAT_W_DEF-1:0]           data;
    } mem_req_t;

    typedef struct packed {
        logic [SRC_W_DEF+IDX_W_DEF-1:0] idx;
        logic                           err;
        logic                           rnw;
        logic [DAT_W_DEF-1:0]           data;
    } mem_resp_t;

endpackage

// File: rtl/mem_arb_if.sv
// Memory-side port of the arbiter: tagged request channel out, tagged response channel in.
interface mem_arb_if #(
    parameter int SRC_W = 1,
    parameter int IDX_W = 4,
    parameter int MCN_W = 36,
    parameter int PCN_W = 28,
    parameter int DAT_W = 512
);
    logic                   mem_req_o_valid;
    logic                   mem_req_o_ready;
    logic [SRC_W+IDX_W-1:0] mem_req_o_bits_idx;
    logic                   mem_req_o_bits_rnw;
    logic [MCN_W-1:0]       mem_req_o_bits_mcn;
    logic [PCN_W-1:0]       mem_req_o_bits_pcn;
    logic [DAT_W-1:0]       mem_req_o_bits_data;

    logic                   mem_resp_i_valid;
    logic                   mem_resp_i_ready;
    logic [SRC_W+IDX_W-1:0] mem_resp_i_bits_idx;
    logic                   mem_resp_i_bits_err;
    logic                   mem_resp_i_bits_rnw;
    logic [DAT_W-1:0]       mem_resp_i_bits_data;

    modport master (
        output mem_req_o_valid, mem_req_o_bits_idx, mem_req_o_bits_rnw,
               mem_req_o_bits_mcn, mem_req_o_bits_pcn, mem_req_o_bits_data,
        input  mem_req_o_ready,
        input  mem_resp_i_valid, mem_resp_i_bits_idx, mem_resp_i_bits_err,
               mem_resp_i_bits_rnw, mem_resp_i_bits_data,
        output mem_resp_i_ready
    );

    modport slave (
        input  mem_req_o_valid, mem_req_o_bits_idx, mem_req_o_bits_rnw,
               mem_req_o_bits_mcn, mem_req_o_bits_pcn, mem_req_o_bits_data,
        output mem_req_o_ready,
        output mem_resp_i_valid, mem_resp_i_bits_idx, mem_resp_i_bits_err,
               mem_resp_i_bits_rnw, mem_resp_i_bits_data,
        input  mem_resp_i_ready
    );

endinterface

// File: rtl/mem_arb_rr_arb.sv
// N-way round-robin arbiter; the priority pointer only advances past a grant that was accepted.
module rr_arb
    import mem_arb_pkg::*;
#(
    parameter int  N     = 2,
    localparam int SRC_W = src_w(N)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             accept,
    output logic [N-1:0]     grant,
    output logic [SRC_W-1:0] grant_idx,
    output logic             any
);
    logic [SRC_W-1:0] ptr;
    logic [SRC_W-1:0] cand;

    // Scan from ptr upwards, wrapping at N-1, and keep the first requester found.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = SRC_W'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (grant_idx == SRC_W'(N - 1)) ? '0 : grant_idx + SRC_W'(1);
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Shares one memory port among N requesters: round-robin with per-source credits, one output
// register stage, source id tagged into the memory idx and used to route responses back.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int  N       = 2,
    parameter int  IDX_W   = 4,
    parameter int  MCN_W   = 36,
    parameter int  PCN_W   = 28,
    parameter int  DAT_W   = 512,
    parameter int  MAX_OUT = MAX_OUT_DEF,
    localparam int SRC_W   = src_w(N)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N-1:0]       req_i_valid,
    output logic [N-1:0]       req_i_ready,
    input  logic [N*IDX_W-1:0] req_i_bits_idx,
    input  logic [N-1:0]       req_i_bits_rnw,
    input  logic [N*MCN_W-1:0] req_i_bits_mcn,
    input  logic [N*PCN_W-1:0] req_i_bits_pcn,
    input  logic [N*DAT_W-1:0] req_i_bits_data,
    output logic [N-1:0]       resp_o_valid,
    input  logic [N-1:0]       resp_o_ready,
    output logic [IDX_W-1:0]   resp_o_bits_idx,
    output logic               resp_o_bits_err,
    output logic               resp_o_bits_rnw,
    output logic [DAT_W-1:0]   resp_o_bits_data,
    mem_arb_if.master          mem,
    output logic               idle_o,
    output logic               drop_o
);
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [N-1:0]            eligible, grant, inc, dec, rsp_hit;
    logic [SRC_W-1:0]        grant_idx, rsp_src;
    logic                    any_grant, out_free, ld, out_vld, out_vld_nxt;
    logic                    rsp_legal, rsp_rdy;
    logic [N-1:0][CNT_W-1:0] cnt, cnt_nxt;

    logic [IDX_W-1:0]        sel_idx;
    logic                    sel_rnw;
    logic [MCN_W-1:0]        sel_mcn;
    logic [PCN_W-1:0]        sel_pcn;
    logic [DAT_W-1:0]        sel_data;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < N; i++) begin
            eligible[i] = req_i_valid[i] && (cnt[i] != CNT_W'(MAX_OUT));
        end
    end

    rr_arb #(.N(N)) u_rr (
        .clock     (clock),
        .reset     (reset),
        .req       (eligible),
        .accept    (ld),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any_grant)
    );

    assign out_free    = !out_vld || mem.mem_req_o_ready;
    assign ld          = any_grant && out_free;
    assign req_i_ready = grant & {N{out_free}};
    assign out_vld_nxt = ld || (out_vld && !mem.mem_req_o_ready);

    always_comb begin
        sel_idx  = '0;
        sel_rnw  = 1'b0;
        sel_mcn  = '0;
        sel_pcn  = '0;
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_idx  = req_i_bits_idx[i*IDX_W +: IDX_W];
                sel_rnw  = req_i_bits_rnw[i];
                sel_mcn  = req_i_bits_mcn[i*MCN_W +: MCN_W];
                sel_pcn  = req_i_bits_pcn[i*PCN_W +: PCN_W];
                sel_data = req_i_bits_data[i*DAT_W +: DAT_W];
            end
        end
    end

    // Unmatched tags (only possible for non-power-of-2 N) are accepted and discarded.
    assign rsp_src = mem.mem_resp_i_bits_idx[SRC_W+IDX_W-1 -: SRC_W];

    always_comb begin
        rsp_hit   = '0;
        rsp_legal = 1'b0;
        rsp_rdy   = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (rsp_src == SRC_W'(i)) begin
                rsp_hit[i] = 1'b1;
                rsp_legal  = 1'b1;
                rsp_rdy    = resp_o_ready[i];
            end
        end
    end

    assign resp_o_valid         = rsp_hit & {N{mem.mem_resp_i_valid}};
    assign mem.mem_resp_i_ready = rsp_rdy;
    assign resp_o_bits_idx      = mem.mem_resp_i_bits_idx[IDX_W-1:0];
    assign resp_o_bits_err      = mem.mem_resp_i_bits_err;
    assign resp_o_bits_rnw      = mem.mem_resp_i_bits_rnw;
    assign resp_o_bits_data     = mem.mem_resp_i_bits_data;

    // A response to an empty counter is still delivered but must not wrap the count.
    always_comb begin
        inc     = grant & {N{ld}};
        dec     = '0;
        cnt_nxt = cnt;
        for (int i = 0; i < N; i++) begin
            dec[i] = mem.mem_resp_i_valid && rsp_rdy && rsp_hit[i] && (cnt[i] != '0);
            case ({inc[i], dec[i]})
                2'b10:   cnt_nxt[i] = cnt[i] + CNT_W'(1);
                2'b01:   cnt_nxt[i] = cnt[i] - CNT_W'(1);
                default: cnt_nxt[i] = cnt[i];
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            out_vld <= 1'b0;
            cnt     <= '0;
            idle_o  <= 1'b1;
            drop_o  <= 1'b0;
        end else begin
            out_vld <= out_vld_nxt;
            cnt     <= cnt_nxt;
            idle_o  <= !out_vld_nxt && (cnt_nxt == '0);
            drop_o  <= mem.mem_resp_i_valid && !rsp_legal;
        end
    end

    always_ff @(posedge clock) begin
        if (ld) begin
            mem.mem_req_o_bits_idx  <= {grant_idx, sel_idx};
            mem.mem_req_o_bits_rnw  <= sel_rnw;
            mem.mem_req_o_bits_mcn  <= sel_mcn;
            mem.mem_req_o_bits_pcn  <= sel_pcn;
            mem.mem_req_o_bits_data <= sel_data;
        end
    end

    assign mem.mem_req_o_valid = out_vld;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: a 2-source instance with two credits and a 3-source instance
// for illegal-tag and mid-operation reset behaviour.
module tb_mem_arb;
    import mem_arb_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int num_compared   = 0;
    int num_mismatched = 0;

    logic [1:0]    a_req_valid, a_req_ready, a_req_rnw, a_resp_valid, a_resp_ready;
    logic [7:0]    a_req_idx;
    logic [71:0]   a_req_mcn;
    logic [55:0]   a_req_pcn;
    logic [1023:0] a_req_data;
    logic [3:0]    a_resp_idx;
    logic          a_resp_err, a_resp_rnw, a_idle, a_drop;
    logic [511:0]  a_resp_data;

    logic [2:0]    b_req_valid, b_req_ready, b_req_rnw, b_resp_valid, b_resp_ready;
    logic [11:0]   b_req_idx;
    logic [107:0]  b_req_mcn;
    logic [83:0]   b_req_pcn;
    logic [1535:0] b_req_data;
    logic [3:0]    b_resp_idx;
    logic          b_resp_err, b_resp_rnw, b_idle, b_drop;
    logic [511:0]  b_resp_data;

    logic          exp_hi;

    mem_arb_if #(.SRC_W(1), .IDX_W(4), .MCN_W(36), .PCN_W(28), .DAT_W(512)) a_mem ();
    mem_arb_if #(.SRC_W(2), .IDX_W(4), .MCN_W(36), .PCN_W(28), .DAT_W(512)) b_mem ();

    mem_arb #(.N(2), .MAX_OUT(2)) dut_a (
        .clock            (clock),
        .reset            (reset),
        .req_i_valid      (a_req_valid),
        .req_i_ready      (a_req_ready),
        .req_i_bits_idx   (a_req_idx),
        .req_i_bits_rnw   (a_req_rnw),
        .req_i_bits_mcn   (a_req_mcn),
        .req_i_bits_pcn   (a_req_pcn),
        .req_i_bits_data  (a_req_data),
        .resp_o_valid     (a_resp_valid),
        .resp_o_ready     (a_resp_ready),
        .resp_o_bits_idx  (a_resp_idx),
        .resp_o_bits_err  (a_resp_err),
        .resp_o_bits_rnw  (a_resp_rnw),
        .resp_o_bits_data (a_resp_data),
        .mem              (a_mem),
        .idle_o           (a_idle),
        .drop_o           (a_drop)
    );

    mem_arb #(.N(3)) dut_b (
        .clock            (clock),
        .reset            (reset),
        .req_i_valid      (b_req_valid),
        .req_i_ready      (b_req_ready),
        .req_i_bits_idx   (b_req_idx),
        .req_i_bits_rnw   (b_req_rnw),
        .req_i_bits_mcn   (b_req_mcn),
        .req_i_bits_pcn   (b_req_pcn),
        .req_i_bits_data  (b_req_data),
        .resp_o_valid     (b_resp_valid),
        .resp_o_ready     (b_resp_ready),
        .resp_o_bits_idx  (b_resp_idx),
        .resp_o_bits_err  (b_resp_err),
        .resp_o_bits_rnw  (b_resp_rnw),
        .resp_o_bits_data (b_resp_data),
        .mem              (b_mem),
        .idle_o           (b_idle),
        .drop_o           (b_drop)
    );

    task automatic checkOutput(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        num_compared++;
        if (obs !== exp) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int src, input logic [3:0] idx, input logic [35:0] mcn);
        a_req_idx[src*4 +: 4]      = idx;
        a_req_rnw[src]             = 1'b1;
        a_req_mcn[src*36 +: 36]    = mcn;
        a_req_pcn[src*28 +: 28]    = mcn[27:0];
        a_req_data[src*512 +: 512] = {476'd0, mcn};
    endtask

    task automatic driveResp(input logic vld, input logic [4:0] idx, input logic [1:0] rdy);
        a_mem.mem_resp_i_valid     = vld;
        a_mem.mem_resp_i_bits_idx  = idx;
        a_mem.mem_resp_i_bits_err  = 1'b0;
        a_mem.mem_resp_i_bits_rnw  = 1'b1;
        a_mem.mem_resp_i_bits_data = 512'(idx);
        a_resp_ready               = rdy;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic mem_req_t expReq(input logic src, input logic [3:0] idx, input logic [35:0] mcn);
        mem_req_t r;
        r.idx  = {src, idx};
        r.rnw  = 1'b1;
        r.mcn  = mcn;
        r.pcn  = mcn[27:0];
        r.data = {476'd0, mcn};
        return r;
    endfunction

    function automatic mem_req_t obsReq();
        mem_req_t r;
        r.idx  = a_mem.mem_req_o_bits_idx;
        r.rnw  = a_mem.mem_req_o_bits_rnw;
        r.mcn  = a_mem.mem_req_o_bits_mcn;
        r.pcn  = a_mem.mem_req_o_bits_pcn;
        r.data = a_mem.mem_req_o_bits_data;
        return r;
    endfunction

    initial begin
        a_req_valid = '0; a_req_rnw = '0; a_req_idx = '0; a_req_mcn = '0;
        a_req_pcn = '0; a_req_data = '0;
        a_mem.mem_req_o_ready = 1'b1;
        driveResp(1'b0, 5'h00, 2'b11);
        b_req_valid = '0; b_req_rnw = '0; b_req_idx = '0; b_req_mcn = '0;
        b_req_pcn = '0; b_req_data = '0; b_resp_ready = '0;
        b_mem.mem_req_o_ready = 1'b1;
        b_mem.mem_resp_i_valid = 1'b0; b_mem.mem_resp_i_bits_idx = '0;
        b_mem.mem_resp_i_bits_err = 1'b0; b_mem.mem_resp_i_bits_rnw = 1'b0;
        b_mem.mem_resp_i_bits_data = '0;

        tick();
        tick();
        checkOutput("rst_vld", 640'(a_mem.mem_req_o_valid), 640'(0));
        checkOutput("rst_idle", 640'(a_idle), 640'(1));
        checkOutput("rst_drop", 640'(a_drop), 640'(0));
        checkOutput("rst_idle_b", 640'(b_idle), 640'(1));
        reset = 1'b1;
        tick();

        applyStimulus(0, 4'h3, 36'h12345);
        a_req_valid = 2'b01;
        #1 checkOutput("ss_ready", 640'(a_req_ready), 640'(2'b01));
        tick();
        a_req_valid = 2'b00;
        checkOutput("ss_vld", 640'(a_mem.mem_req_o_valid), 640'(1));
        checkOutput("ss_req", 640'(obsReq()), 640'(expReq(1'b0, 4'h3, 36'h12345)));
        checkOutput("ss_busy", 640'(a_idle), 640'(0));
        tick();
        checkOutput("ss_drain", 640'(a_mem.mem_req_o_valid), 640'(0));
        checkOutput("ss_cnt_busy", 640'(a_idle), 640'(0));
        driveResp(1'b1, 5'h03, 2'b11);
        #1;
        checkOutput("ss_rsp_vld", 640'(a_resp_valid), 640'(2'b01));
        checkOutput("ss_rsp_idx", 640'(a_resp_idx), 640'(3));
        checkOutput("ss_rsp_data", 640'(a_resp_data), 640'(3));
        checkOutput("ss_rsp_rdy", 640'(a_mem.mem_resp_i_ready), 640'(1));
        tick();
        driveResp(1'b0, 5'h00, 2'b11);
        checkOutput("ss_idle", 640'(a_idle), 640'(1));

        // The pointer sits at 1 after the single-source grant, so grants run 1,0,1,0.
        applyStimulus(0, 4'h1, 36'h100);
        applyStimulus(1, 4'h2, 36'h200);
        a_req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_hi = (k % 2 == 0);
            #1 checkOutput("alt_grant", 640'(a_req_ready), 640'(exp_hi ? 2'b10 : 2'b01));
            tick();
            checkOutput("alt_vld", 640'(a_mem.mem_req_o_valid), 640'(1));
            checkOutput("alt_tag", 640'(a_mem.mem_req_o_bits_idx), 640'(exp_hi ? 5'h12 : 5'h01));
        end
        #1 checkOutput("lim_both", 640'(a_req_ready), 640'(2'b00));
        a_req_valid = 2'b00;
        tick();
        checkOutput("lim_drain", 640'(a_mem.mem_req_o_valid), 640'(0));

        driveResp(1'b1, 5'h12, 2'b11);
        #1;
        checkOutput("rsp1_vld", 640'(a_resp_valid), 640'(2'b10));
        checkOutput("rsp1_idx", 640'(a_resp_idx), 640'(2));
        tick();
        tick();

        a_req_valid = 2'b11;
        driveResp(1'b1, 5'h01, 2'b11);
        #1 checkOutput("lim_src0_blocked", 640'(a_req_ready), 640'(2'b10));
        tick();
        driveResp(1'b0, 5'h00, 2'b11);
        a_req_valid = 2'b01;
        #1 checkOutput("lim_reelig", 640'(a_req_ready), 640'(2'b01));
        checkOutput("lim_src1_tag", 640'(a_mem.mem_req_o_bits_idx), 640'(5'h12));

        driveResp(1'b1, 5'h01, 2'b11);
        tick();
        driveResp(1'b0, 5'h00, 2'b11);
        #1 checkOutput("sim_cnt_kept", 640'(a_req_ready), 640'(2'b01));
        tick();
        #1 checkOutput("sim_at_limit", 640'(a_req_ready), 640'(2'b00));

        a_mem.mem_req_o_ready = 1'b0;
        applyStimulus(1, 4'h7, 36'h777);
        a_req_valid = 2'b10;
        for (int k = 0; k < 5; k++) begin
            #1;
            checkOutput("bp_ready", 640'(a_req_ready), 640'(2'b00));
            checkOutput("bp_vld", 640'(a_mem.mem_req_o_valid), 640'(1));
            checkOutput("bp_hold", 640'(obsReq()), 640'(expReq(1'b0, 4'h1, 36'h100)));
            tick();
        end
        a_mem.mem_req_o_ready = 1'b1;
        #1 checkOutput("bp_release", 640'(a_req_ready), 640'(2'b10));
        tick();
        checkOutput("bp_next", 640'(obsReq()), 640'(expReq(1'b1, 4'h7, 36'h777)));
        a_req_valid = 2'b00;
        tick();

        driveResp(1'b1, 5'h12, 2'b11);
        tick();
        tick();
        applyStimulus(1, 4'h4, 36'h444);
        a_req_valid = 2'b10;
        driveResp(1'b1, 5'h01, 2'b10);
        #1;
        checkOutput("stall_rdy", 640'(a_mem.mem_resp_i_ready), 640'(0));
        checkOutput("stall_fwd", 640'(a_resp_valid), 640'(2'b01));
        checkOutput("stall_req", 640'(a_req_ready), 640'(2'b10));
        tick();
        a_req_valid = 2'b00;
        checkOutput("stall_tag", 640'(a_mem.mem_req_o_bits_idx), 640'(5'h14));

        driveResp(1'b1, 5'h01, 2'b11);
        tick();
        tick();
        driveResp(1'b1, 5'h12, 2'b11);
        tick();
        driveResp(1'b0, 5'h00, 2'b11);
        checkOutput("drain_idle", 640'(a_idle), 640'(1));

        driveResp(1'b1, 5'h12, 2'b11);
        #1 checkOutput("uf_fwd", 640'(a_resp_valid), 640'(2'b10));
        tick();
        driveResp(1'b0, 5'h00, 2'b11);
        checkOutput("uf_idle", 640'(a_idle), 640'(1));

        b_mem.mem_resp_i_valid    = 1'b1;
        b_mem.mem_resp_i_bits_idx = 6'h35;
        b_resp_ready              = 3'b000;
        #1;
        checkOutput("ill_rdy", 640'(b_mem.mem_resp_i_ready), 640'(1));
        checkOutput("ill_vld", 640'(b_resp_valid), 640'(3'b000));
        checkOutput("ill_drop_early", 640'(b_drop), 640'(0));
        tick();
        b_mem.mem_resp_i_valid = 1'b0;
        checkOutput("ill_drop", 640'(b_drop), 640'(1));
        tick();
        checkOutput("ill_drop_end", 640'(b_drop), 640'(0));

        b_mem.mem_resp_i_valid    = 1'b1;
        b_mem.mem_resp_i_bits_idx = 6'h25;
        b_resp_ready              = 3'b100;
        #1;
        checkOutput("b_rsp_vld", 640'(b_resp_valid), 640'(3'b100));
        checkOutput("b_rsp_idx", 640'(b_resp_idx), 640'(5));
        tick();
        b_mem.mem_resp_i_valid = 1'b0;

        b_mem.mem_req_o_ready = 1'b0;
        b_req_idx[11:8]       = 4'h9;
        b_req_valid           = 3'b100;
        tick();
        b_req_valid = 3'b000;
        checkOutput("b_vld", 640'(b_mem.mem_req_o_valid), 640'(1));
        checkOutput("b_tag", 640'(b_mem.mem_req_o_bits_idx), 640'(6'h29));
        checkOutput("b_busy", 640'(b_idle), 640'(0));
        reset = 1'b0;
        tick();
        checkOutput("rst_mid_vld", 640'(b_mem.mem_req_o_valid), 640'(0));
        checkOutput("rst_mid_idle", 640'(b_idle), 640'(1));
        reset = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
